// File: rtl/cpu_subsys_sram_resp_if.sv
// Native CPU-subsystem memory interface between the host bridge (master)
// and an SRAM responder (slave).
interface cpu_subsys_sram_resp_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_subsys_sram_resp.sv
// SRAM responder on the native memory interface: programmable wait states,
// byte-lane writes, and abort when the initiator withdraws valid while waiting.
module cpu_subsys_sram_resp #(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    cpu_subsys_sram_resp_if.slave  mem
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("cpu_subsys_sram_resp: WAIT_STATES must be in 0..15");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 29) begin : g_bad_depth
        $error("cpu_subsys_sram_resp: DEPTH_LOG2 must be in 1..29");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0] idx_reg, idx_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [3:0]            wstrb_reg, wstrb_next;
    logic                  ready_reg;

    logic                  access;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_wstrb;
    logic [31:0]           rdata_word;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.mem_addr[31:DEPTH_LOG2+2], mem.mem_addr[1:0]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        access     = 1'b0;
        acc_idx    = idx_reg;
        acc_wdata  = wdata_reg;
        acc_wstrb  = wstrb_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem.mem_valid) begin
                    idx_next   = mem.mem_addr[DEPTH_LOG2+1:2];
                    wdata_next = mem.mem_wdata;
                    wstrb_next = mem.mem_wstrb;
                    cnt_next   = WAIT_CNT;
                    if (NO_WAIT) begin
                        // Zero wait states: commit straight from the bus this edge.
                        access     = 1'b1;
                        acc_idx    = mem.mem_addr[DEPTH_LOG2+1:2];
                        acc_wdata  = mem.mem_wdata;
                        acc_wstrb  = mem.mem_wstrb;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem.mem_valid) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == 4'd1) begin
                    access     = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= '0;
            wdata_reg <= 32'h0;
            wstrb_reg <= 4'h0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            ready_reg <= (state_next == ST_RESP);
        end
    end

    // One byte-wide RAM per lane so each strobe maps to its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] sram [DEPTH];
        logic [7:0] rdata_byte_reg;

        always_ff @(posedge sys_clk) begin
            if (access && acc_wstrb[gi]) begin
                sram[acc_idx] <= acc_wdata[8*gi +: 8];
            end
        end

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_byte_reg <= 8'h0;
            end else if (access && (acc_wstrb == 4'h0)) begin
                rdata_byte_reg <= sram[acc_idx];
            end
        end

        assign rdata_word[8*gi +: 8] = rdata_byte_reg;
    end

    assign mem.mem_ready = ready_reg;
    assign mem.mem_rdata = rdata_word;

endmodule
